// File: rtl/transpose_pkg.sv
// Shared state encoding and default sizing for the transpose feeder.
package transpose_pkg;
  localparam int NUM_WORDS     = 64;
  localparam int MAX_DATA_PREC = 8;
  localparam int FIFO_DEPTH    = 128;

  typedef enum logic [1:0] {IDLE, START, STREAM, WAIT} feeder_state_t;
endpackage

// File: rtl/feeder_fifo.sv
// Single-clock FIFO with a combinational head read so a pop and its data share a cycle.
// Push and pop in the same cycle leave the occupancy count unchanged.
module feeder_fifo #(
  parameter int  WIDTH = 32,
  parameter int  DEPTH = 128,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/transpose_feeder.sv
// Buffers host activation words and launches NUM_WORDS-word batches into the transposer.
// Defining TRANSPOSE_FEEDER_PAD_EN adds a flush port that zero-pads a partial batch.
module transpose_feeder #(
  parameter int  NUM_WORDS     = transpose_pkg::NUM_WORDS,
  parameter int  XLEN          = 32,
  parameter int  MVU_ADDR_LEN  = 32,
  parameter int  MAX_DATA_PREC = transpose_pkg::MAX_DATA_PREC,
  parameter int  FIFO_DEPTH    = transpose_pkg::FIFO_DEPTH,
  localparam int CW            = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [XLEN-1:0]         s_word,
  input  logic                    cfg_load,
  input  logic [31:0]             cfg_prec,
  input  logic [MVU_ADDR_LEN-1:0] cfg_baddr,
  output logic                    cfg_err,
  output logic                    tr_start,
  output logic [31:0]             tr_prec,
  output logic [MVU_ADDR_LEN-1:0] tr_baddr,
  output logic [XLEN-1:0]         tr_word,
  input  logic                    tr_busy,
`ifdef TRANSPOSE_FEEDER_PAD_EN
  input  logic                    flush,
`endif
  output logic [CW-1:0]           fifo_count,
  output logic [15:0]             batches_done
);
  import transpose_pkg::*;

  localparam int             IW       = $clog2(NUM_WORDS) + 1;
  localparam logic [CW-1:0]  NW_CNT   = CW'(NUM_WORDS);
  localparam logic [IW-1:0]  NW_IDX   = IW'(NUM_WORDS);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_WORDS - 1);

  feeder_state_t           state_q, state_d;
  logic                    tr_start_q, tr_start_d, cfg_err_q, cfg_err_d, pad_q, pad_d;
  logic [31:0]             tr_prec_q, tr_prec_d, prec_q, prec_d;
  logic [MVU_ADDR_LEN-1:0] tr_baddr_q, tr_baddr_d, addr_q, addr_d;
  logic [XLEN-1:0]         tr_word_q, tr_word_d, head_word;
  logic [15:0]             batches_done_q, batches_done_d;
  logic [IW-1:0]           idx_q, idx_d, len_q, len_d;
  logic                    push, pop, full, empty, cfg_ok, batch_ready, launch, pad_arm;
  logic [CW-1:0]           cnt_ahead;

  feeder_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (s_word),
    .pop     (pop),
    .rd_data (head_word),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  assign s_ready   = !full;
  assign push      = s_valid && s_ready;
  // Counting the word accepted this cycle lets tr_start follow the final accept directly.
  assign cnt_ahead   = fifo_count + CW'(push);
  assign batch_ready = (cnt_ahead >= NW_CNT);
  assign cfg_ok      = cfg_load && (cfg_prec != 32'd0) && (cfg_prec <= 32'(MAX_DATA_PREC));

`ifdef TRANSPOSE_FEEDER_PAD_EN
  assign pad_arm = flush && (state_q == IDLE) && !empty && (fifo_count < NW_CNT);
`else
  assign pad_arm = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    tr_start_d     = 1'b0;
    tr_prec_d      = tr_prec_q;
    tr_baddr_d     = tr_baddr_q;
    tr_word_d      = tr_word_q;
    batches_done_d = batches_done_q;
    idx_d          = idx_q;
    len_d          = len_q;
    pop            = 1'b0;
    launch         = 1'b0;
    cfg_err_d      = cfg_load && !cfg_ok;
    prec_d         = cfg_ok ? cfg_prec : prec_q;
    addr_d         = cfg_ok ? cfg_baddr : addr_q;
    pad_d          = pad_q || pad_arm;

    case (state_q)
      IDLE: launch = !tr_busy && (batch_ready || pad_q);
      START: begin
        pop       = !empty;
        tr_word_d = head_word;
        idx_d     = '0;
        pad_d     = 1'b0;
        state_d   = STREAM;
        // A config load in this cycle replaces the advanced address for the next batch.
        if (!cfg_ok) begin
          addr_d = addr_q + MVU_ADDR_LEN'(prec_q);
        end
      end
      STREAM: begin
        if (idx_q == LAST_IDX) begin
          state_d = WAIT;
        end else begin
          idx_d = idx_q + 1'b1;
          if (idx_d < len_q) begin
            pop       = 1'b1;
            tr_word_d = head_word;
          end else begin
            tr_word_d = '0;
          end
        end
      end
      WAIT: begin
        if (!tr_busy) begin
          batches_done_d = batches_done_q + 1'b1;
          state_d        = IDLE;
          launch         = batch_ready;
        end
      end
      default: state_d = IDLE;
    endcase

    // Batch parameters are captured as the START cycle is entered so they accompany tr_start.
    if (launch) begin
      state_d    = START;
      tr_start_d = 1'b1;
      tr_prec_d  = prec_d;
      tr_baddr_d = addr_d;
      len_d      = batch_ready ? NW_IDX : IW'(cnt_ahead);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      tr_start_q     <= 1'b0;
      cfg_err_q      <= 1'b0;
      pad_q          <= 1'b0;
      tr_prec_q      <= 32'(MAX_DATA_PREC);
      prec_q         <= 32'(MAX_DATA_PREC);
      tr_baddr_q     <= '0;
      addr_q         <= '0;
      tr_word_q      <= '0;
      batches_done_q <= '0;
      idx_q          <= '0;
      len_q          <= NW_IDX;
    end else begin
      state_q        <= state_d;
      tr_start_q     <= tr_start_d;
      cfg_err_q      <= cfg_err_d;
      pad_q          <= pad_d;
      tr_prec_q      <= tr_prec_d;
      prec_q         <= prec_d;
      tr_baddr_q     <= tr_baddr_d;
      addr_q         <= addr_d;
      tr_word_q      <= tr_word_d;
      batches_done_q <= batches_done_d;
      idx_q          <= idx_d;
      len_q          <= len_d;
    end
  end

  assign tr_start     = tr_start_q;
  assign cfg_err      = cfg_err_q;
  assign tr_prec      = tr_prec_q;
  assign tr_baddr     = tr_baddr_q;
  assign tr_word      = tr_word_q;
  assign batches_done = batches_done_q;
endmodule

// File: tb/tb_transpose_feeder.sv
// Directed bench for transpose_feeder: scoreboarded word stream, config rules, stall, padding, reset.
module tb_transpose_feeder;
  localparam int NW    = 64;
  localparam int DEPTH = 128;

  logic        clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, cfg_load = 1'b0, tr_busy = 1'b0;
  logic [31:0] s_word = '0, cfg_prec = '0, cfg_baddr = '0;
  logic        s_ready, cfg_err, tr_start;
  logic [31:0] tr_prec, tr_baddr, tr_word;
  logic [7:0]  fifo_count;
  logic [15:0] batches_done;
`ifdef TRANSPOSE_FEEDER_PAD_EN
  logic        flush = 1'b0;
`endif

  transpose_feeder dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_word(s_word),
    .cfg_load(cfg_load), .cfg_prec(cfg_prec), .cfg_baddr(cfg_baddr), .cfg_err(cfg_err),
    .tr_start(tr_start), .tr_prec(tr_prec), .tr_baddr(tr_baddr), .tr_word(tr_word),
    .tr_busy(tr_busy),
`ifdef TRANSPOSE_FEEDER_PAD_EN
    .flush(flush),
`endif
    .fifo_count(fifo_count), .batches_done(batches_done)
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0;
  int cyc = 0, starts = 0, stream_left = 0, k = 0, busy_cnt = 0, last_acc = 0, starts_before = 0;
  int busy_len = 70, pad_real = NW, cur_real = NW;
  bit chk_latency = 1'b0, saw_full = 1'b0;
  logic [31:0] sb[$];
  logic [63:0] exp_cfg[$];
  logic [63:0] cur_cfg;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: scoreboard, transposer busy model, launch checks.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      sb.delete();
      stream_left = 0;
      busy_cnt    = 0;
      tr_busy     = 1'b0;
    end else begin
      if (tr_start) begin
        starts++;
        check("start_busy_low", tr_busy, 0);
        if (chk_latency) check("start_latency", cyc - last_acc, 1);
        check("start_expected", exp_cfg.size() != 0, 1);
        if (exp_cfg.size() != 0) begin
          cur_cfg = exp_cfg.pop_front();
          check("tr_prec", tr_prec, cur_cfg[63:32]);
          check("tr_baddr", tr_baddr, cur_cfg[31:0]);
        end
        $display("batch %0d launched at cycle %0d prec=%0d baddr=0x%0h", starts, cyc, tr_prec, tr_baddr);
        stream_left = NW;
        k           = 0;
        cur_real    = pad_real;
        tr_busy     = 1'b1;
        busy_cnt    = busy_len;
      end else begin
        if (stream_left > 0) begin
          if (k < cur_real) begin
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) check("tr_word", tr_word, sb.pop_front());
          end else begin
            check("tr_word_pad", tr_word, 0);
          end
          k++;
          stream_left--;
        end
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) tr_busy = 1'b0;
        end
      end
      if (fifo_count == DEPTH) begin
        saw_full = 1'b1;
        check("s_ready_full", s_ready, 0);
      end
      if (s_valid && s_ready) begin
        sb.push_back(s_word);
        last_acc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int n, input logic [31:0] base);
    int guard;
    for (int i = 0; i < n; i++) begin
      guard   = 0;
      s_valid = 1'b1;
      s_word  = base + i;
      @(negedge clk);
      while (!s_ready && guard < 2000) begin
        guard++;
        @(negedge clk);
      end
      if (!s_ready) check("push_ready", s_ready, 1);
      step();
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_batches(input int target, input int budget, input string tag);
    int n = 0;
    while (batches_done != 16'(target) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, batches_done, target);
    step();
  endtask

  task automatic wait_starts(input int target, input int budget);
    int n = 0;
    while (starts < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", starts, target);
    step();
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_tr_start", tr_start, 0);
    check("rst_tr_prec", tr_prec, 8);
    check("rst_tr_baddr", tr_baddr, 0);
    check("rst_tr_word", tr_word, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_batches_done", batches_done, 0);
    step();
    rst_n = 1'b1;

    // Single batch with launch-latency check
    cfg_load = 1'b1; cfg_prec = 32'd4; cfg_baddr = 32'h100;
    step();
    cfg_load = 1'b0;
    check("cfg_err_legal", cfg_err, 0);
    exp_cfg.push_back({32'd4, 32'h100});
    chk_latency = 1'b1;
    push_words(64, 32'd0);
    wait_batches(1, 400, "batches_single");
    chk_latency = 1'b0;
    check("sb_empty_single", sb.size(), 0);

    // Illegal precision loads are rejected
    cfg_load = 1'b1; cfg_prec = 32'd9; cfg_baddr = 32'h999;
    step();
    cfg_load = 1'b0;
    check("cfg_err_pulse", cfg_err, 1);
    step();
    check("cfg_err_clear", cfg_err, 0);
    cfg_load = 1'b1; cfg_prec = 32'd0;
    step();
    cfg_load = 1'b0;
    check("cfg_err_zero", cfg_err, 1);
    step();

    // Back-to-back batches with a long busy so the FIFO fills
    busy_len = 200;
    exp_cfg.push_back({32'd4, 32'h104});
    exp_cfg.push_back({32'd4, 32'h108});
    exp_cfg.push_back({32'd4, 32'h10C});
    push_words(200, 32'h1000);
    wait_batches(4, 1500, "batches_stall");
    check("saw_full", saw_full, 1);
    check("leftover_count", fifo_count, 8);
    check("sb_leftover", sb.size(), 8);
    busy_len = 70;

    // Config load mid-stream applies to the following batches only
    exp_cfg.push_back({32'd4, 32'h110});
    exp_cfg.push_back({32'd2, 32'h40});
    exp_cfg.push_back({32'd2, 32'h42});
    push_words(56, 32'h2000);
    wait_starts(5, 50);
    repeat (10) step();
    cfg_load = 1'b1; cfg_prec = 32'd2; cfg_baddr = 32'h40;
    step();
    cfg_load = 1'b0;
    check("cfg_err_mid", cfg_err, 0);
    push_words(128, 32'h3000);
    wait_batches(7, 1000, "batches_cfg");
    check("sb_empty_cfg", sb.size(), 0);

    // Partial batch
    push_words(10, 32'd1);
`ifdef TRANSPOSE_FEEDER_PAD_EN
    exp_cfg.push_back({32'd2, 32'h44});
    pad_real = 10;
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_batches(8, 300, "batches_pad");
    pad_real = NW;
    check("sb_empty_pad", sb.size(), 0);
    check("fifo_empty_pad", fifo_count, 0);
    exp_cfg.push_back({32'd2, 32'h46});
    push_words(64, 32'h4000);
    wait_starts(9, 50);
`else
    repeat (200) step();
    check("no_start_partial", starts, 7);
    check("partial_held", fifo_count, 10);
    exp_cfg.push_back({32'd2, 32'h44});
    push_words(54, 32'h4000);
    wait_starts(8, 50);
`endif

    // Reset mid-stream aborts the batch
    starts_before = starts;
    repeat (19) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (100) step();
    check("abort_no_start", starts, starts_before);
    check("abort_tr_start", tr_start, 0);
    check("abort_fifo_count", fifo_count, 0);
    check("abort_s_ready", s_ready, 1);
    check("abort_batches_done", batches_done, 0);
    check("abort_tr_prec", tr_prec, 8);
    check("abort_tr_baddr", tr_baddr, 0);

    // Fresh batch after reset uses default config
    exp_cfg.push_back({32'd8, 32'h0});
    push_words(64, 32'h5000);
    wait_batches(1, 400, "batches_after_rst");
    check("sb_empty_final", sb.size(), 0);
    check("cfg_all_used", exp_cfg.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
